lap_stopwatch: RTL
==================

# lap_stopwatch

Parametrised stopwatch/countdown-timer core with a DIGITS-wide BCD counter, an internal or external tick source with speed scaling, a lap hold, and up/down modes with wrap and zero-alarm reporting. It sits between the board-level debouncers/synchronizers and the 7-segment decoders, and it supersedes the fixed 4-digit stopwatch core. Button inputs are debounced levels, and the block performs its own rising-edge detection.

## Interface
- DIGITS, 4: number of BCD digits (1..8).
- TICK_DIV, 50000: Clk cycles per base tick (≥2).
- SPEED_W, 5: width of Speed.
- Clk  in  1  system clock; all logic on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  debounced level; a rising edge starts or pauses counting.
- Clear  in  1  debounced level; a rising edge zeroes the count.
- Lap  in  1  debounced level; a rising edge toggles the lap hold.
- Load  in  1  debounced level; a rising edge loads LoadValue.
- Dir  in  1  0 = count up, 1 = count down (synchronized level).
- TickSel  in  1  0 = internal prescaler, 1 = ExtTick.
- ExtTick  in  1  debounced level; a rising edge is one tick.
- Speed  in  SPEED_W  tick period = TICK_DIV*(Speed+1) cycles.
- LoadValue  in  4*DIGITS  BCD preset; digit 0 is the LSBs.
- Digits  out  4*DIGITS  displayed BCD value (live count or lap snapshot).
- Running  out  1  high in RUNNING.
- Expired  out  1  high in EXPIRED.
- LapActive  out  1  the lap snapshot is displayed.
- Alarm  out  1  1-cycle pulse when a down-count reaches zero.
- Wrap  out  1  1-cycle pulse on up-count rollover from all-9s to 0.
- TickOut  out  1  1-cycle pulse per applied tick.

## Operation
- Edge detect: rise = In & ~prev.
  - The prev registers for Start, Clear, Lap, Load and ExtTick reset to 1, so an input held high through reset does not fire.
- FSM has three states: STOPPED (reset state), RUNNING and EXPIRED.
  - STOPPED, Start rise: go to RUNNING and clear the prescaler. Exception: if Dir=1 and count=0, Start is ignored.
  - RUNNING, Start rise: go to STOPPED. The prescaler holds its value.
  - RUNNING, down-tick that makes count 0: go to EXPIRED and pulse Alarm.
  - EXPIRED, Start rise: go to STOPPED.
- Clear rise, any state: count=0, prescaler=0, LapActive=0, state=STOPPED.
- Load rise in STOPPED or EXPIRED: count=LoadValue, with any digit >9 saturated to 9; state=STOPPED. Load is ignored in RUNNING.
- Same-cycle priority: Clear > Load > Start > Lap. A lower-priority edge that loses is discarded, not deferred.
- Tick generation runs only in RUNNING.
  - Internal source: a cycle counter runs 0..TICK_DIV-1. At terminal count it wraps, and a speed counter increments. A tick fires when the cycle counter is at terminal and speedcnt ≥ Speed; speedcnt then returns to 0.
  - The ≥ compare makes a mid-run decrease of Speed take effect within one base period.
  - External source (TickSel=1): each ExtTick rise is one tick, and the prescaler is held.
  - Changing TickSel mid-run clears the prescaler.
- Count update on each tick:
  - Up: BCD increment with ripple carry. All-9s goes to all-0 with a Wrap pulse, and counting continues.
  - Down: BCD decrement with ripple borrow.
  - A Dir change applies from the next tick.
- Lap:
  - In RUNNING with LapActive=0, a Lap rise snapshots the count into the lap register and sets LapActive.
  - A Lap rise while LapActive=1 clears it, in any state.
  - All other Lap rises are ignored.
  - The live count keeps advancing while the snapshot is displayed.
- Digits = LapActive ? lap register : count.

## Timing
- All outputs are registered. Reset values: Digits=0, Running=0, Expired=0, LapActive=0, Alarm=0, Wrap=0, TickOut=0.
- A control edge that is first sampled high at clock edge k produces its state/output change after edge k, with no further latency.
- On a tick at edge k, count, TickOut, Wrap and Alarm all update after edge k. Running drops and Expired rises after the same edge as Alarm.
- First internal tick comes exactly TICK_DIV*(Speed+1) cycles after the Start edge.
- Resuming from pause continues from the held prescaler phase.
- Asserting Reset mid-operation aborts immediately to the reset values, the prescaler and lap register clear, and prev registers go to 1.

## Test plan
- Basic up-count: DIGITS=2, TICK_DIV=4, Speed=0, Dir=0; Start rise → TickOut every 4 cycles, first after 4; after 12 ticks Digits=8'h12.
- Wrap: Load 8'h98, Start, 2 ticks → Digits 8'h99 then 8'h00; Wrap is a single pulse on the second tick, and Running stays 1.
- Countdown and alarm: Dir=1, Load 8'h02, Start → 8'h01, then 8'h00 with Alarm for 1 cycle, Expired=1, Running=0. A further Start rise → STOPPED with Expired=0, and Start again is ignored because count=0.
- Lap: running up at 8'h05, Lap rise → Digits frozen at 8'h05 for 3 ticks; second Lap rise → Digits=8'h08.
- Priority and saturation: Clear, Load and Start rising in the same cycle → count 0, STOPPED. Later, Load of LoadValue=8'hA3 in STOPPED → Digits=8'h93.
- Speed/external: Speed=2 → tick period 12 cycles. TickSel=1 with ExtTick held high through reset → no tick; three ExtTick rises → Digits=8'h03.

Source files
------------

// File: rtl/lap_stopwatch.sv
// lap_stopwatch
// Stopwatch / countdown timer core with a DIGITS-wide BCD count, a selectable
// tick source (internal prescaler with speed scaling, or an external tick
// input), a lap snapshot hold, and up/down counting with wrap and zero alarm.
//
// Parameters
//   DIGITS     number of BCD digits (1..8)
//   TICK_DIV   clock cycles per base tick (>= 2)
//   SPEED_W    width of the speed input
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       debounced level, rising edge starts/pauses counting
//   clear       debounced level, rising edge zeroes the count
//   lap         debounced level, rising edge toggles the lap hold
//   load        debounced level, rising edge loads load_value
//   dir         0 = count up, 1 = count down
//   tick_sel    0 = internal prescaler, 1 = ext_tick
//   ext_tick    debounced level, rising edge is one tick
//   speed       tick period = TICK_DIV*(speed+1) cycles
//   load_value  BCD preset, digit 0 in the LSBs
//   digits      displayed BCD value (live count or lap snapshot)
//   running     high while counting
//   expired     high after a down-count reached zero
//   lap_active  the lap snapshot is being displayed
//   alarm       one-cycle pulse when a down-count reaches zero
//   wrap        one-cycle pulse on up-count rollover from all 9s to 0
//   tick_out    one-cycle pulse per applied tick

module lap_stopwatch #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50000,
    parameter int SPEED_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  clear,
    input  logic                  lap,
    input  logic                  load,
    input  logic                  dir,
    input  logic                  tick_sel,
    input  logic                  ext_tick,
    input  logic [SPEED_W-1:0]    speed,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   digits,
    output logic                  running,
    output logic                  expired,
    output logic                  lap_active,
    output logic                  alarm,
    output logic                  wrap,
    output logic                  tick_out
);

    localparam int CW = 4 * DIGITS;
    localparam int CYC_W = $clog2(TICK_DIV);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUNNING = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    // BCD increment with ripple carry; all 9s rolls over to all 0s.
    function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // BCD decrement with ripple borrow; zero rolls under to all 9s.
    function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Clamp any non-decimal preset digit to 9.
    function automatic logic [CW-1:0] bcd_sat(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] all_nines();
        logic [CW-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    localparam logic [CW-1:0] NINES = all_nines();

    state_t              state, state_n;
    logic [CW-1:0]       count, count_n;
    logic [CW-1:0]       lap_reg, lap_reg_n;
    logic                lap_active_n;
    logic [CYC_W-1:0]    cyc_cnt, cyc_n;
    logic [SPEED_W-1:0]  spd_cnt, spd_n;
    logic                tick_sel_q;
    logic                tick, alarm_n, wrap_n;

    logic start_q, clear_q, lap_q, load_q, ext_q;
    logic start_rise, clear_rise, lap_rise, load_rise, ext_rise;
    logic start_ok, load_ok;

    assign start_rise = start    & ~start_q;
    assign clear_rise = clear    & ~clear_q;
    assign lap_rise   = lap      & ~lap_q;
    assign load_rise  = load     & ~load_q;
    assign ext_rise   = ext_tick & ~ext_q;

    // A start press that would begin a down-count from zero is not accepted,
    // and a load press while running is not accepted; neither then blocks a
    // lower-priority edge in the same cycle.
    assign start_ok = start_rise && !(state == STOPPED && dir && count == '0);
    assign load_ok  = load_rise && (state != RUNNING);

    // Previous-level registers for edge detection. They come out of reset
    // high so that a button already held down during reset does not fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q    <= 1'b1;
            clear_q    <= 1'b1;
            lap_q      <= 1'b1;
            load_q     <= 1'b1;
            ext_q      <= 1'b1;
            tick_sel_q <= 1'b0;
        end else begin
            start_q    <= start;
            clear_q    <= clear;
            lap_q      <= lap;
            load_q     <= load;
            ext_q      <= ext_tick;
            tick_sel_q <= tick_sel;
        end
    end

    // State register for the control FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= STOPPED;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic. Tick generation and the count update are worked out
    // first, then the button edges are applied in priority order
    // clear > load > start > lap, each overriding what came before it.
    // Pausing discards a tick landing in the same cycle and leaves the
    // prescaler phase where it was so a resume continues from it.
    always_comb begin
        state_n      = state;
        count_n      = count;
        lap_reg_n    = lap_reg;
        lap_active_n = lap_active;
        cyc_n        = cyc_cnt;
        spd_n        = spd_cnt;
        tick         = 1'b0;
        alarm_n      = 1'b0;
        wrap_n       = 1'b0;

        if (state == RUNNING) begin
            if (tick_sel) begin
                tick = ext_rise;
            end else if (cyc_cnt == CYC_LAST) begin
                cyc_n = '0;
                if (spd_cnt >= speed) begin
                    tick  = 1'b1;
                    spd_n = '0;
                end else begin
                    spd_n = spd_cnt + SPEED_W'(1);
                end
            end else begin
                cyc_n = cyc_cnt + CYC_W'(1);
            end
            if (tick_sel != tick_sel_q) begin
                cyc_n = '0;
                spd_n = '0;
            end
        end

        if (tick) begin
            if (dir) begin
                count_n = bcd_dec(count);
                if (count_n == '0) begin
                    alarm_n = 1'b1;
                    state_n = EXPIRED;
                end
            end else begin
                count_n = bcd_inc(count);
                wrap_n  = (count == NINES);
            end
        end

        if (clear_rise) begin
            count_n      = '0;
            cyc_n        = '0;
            spd_n        = '0;
            lap_active_n = 1'b0;
            state_n      = STOPPED;
            tick         = 1'b0;
            alarm_n      = 1'b0;
            wrap_n       = 1'b0;
        end else if (load_ok) begin
            count_n = bcd_sat(load_value);
            state_n = STOPPED;
        end else if (start_ok) begin
            case (state)
                STOPPED: begin
                    state_n = RUNNING;
                    cyc_n   = '0;
                    spd_n   = '0;
                end
                RUNNING: begin
                    state_n = STOPPED;
                    count_n = count;
                    cyc_n   = cyc_cnt;
                    spd_n   = spd_cnt;
                    tick    = 1'b0;
                    alarm_n = 1'b0;
                    wrap_n  = 1'b0;
                end
                EXPIRED: begin
                    state_n = STOPPED;
                end
                default: begin
                    state_n = STOPPED;
                end
            endcase
        end else if (lap_rise) begin
            if (lap_active) begin
                lap_active_n = 1'b0;
            end else if (state == RUNNING) begin
                lap_active_n = 1'b1;
                lap_reg_n    = count;
            end
        end
    end

    // Datapath and registered outputs. The displayed value is chosen from
    // the next-cycle lap/count values so it changes on the same edge as the
    // event that caused it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            lap_reg    <= '0;
            lap_active <= 1'b0;
            cyc_cnt    <= '0;
            spd_cnt    <= '0;
            digits     <= '0;
            running    <= 1'b0;
            expired    <= 1'b0;
            alarm      <= 1'b0;
            wrap       <= 1'b0;
            tick_out   <= 1'b0;
        end else begin
            count      <= count_n;
            lap_reg    <= lap_reg_n;
            lap_active <= lap_active_n;
            cyc_cnt    <= cyc_n;
            spd_cnt    <= spd_n;
            digits     <= lap_active_n ? lap_reg_n : count_n;
            running    <= (state_n == RUNNING);
            expired    <= (state_n == EXPIRED);
            alarm      <= alarm_n;
            wrap       <= wrap_n;
            tick_out   <= tick;
        end
    end

endmodule
